// File: rtl/rda_accumulator_if.sv
// Stream bundle for rda_accumulator: sample input side, flush, and frame result output side.
// The slave modport is the accumulator's view; master is the upstream/downstream driver view.
interface rda_accumulator_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic [7:0]       in_tag;
    logic             flush;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic [7:0]       out_tag;
    logic             out_ovf;

    modport master (
        output in_valid, in_data, in_tag, flush, out_ready,
        input  in_ready, out_valid, out_data, out_tag, out_ovf
    );

    modport slave (
        input  in_valid, in_data, in_tag, flush, out_ready,
        output in_ready, out_valid, out_data, out_tag, out_ovf
    );
endinterface

// File: rtl/rda_accumulator.sv
// Frame accumulator behind the redundant-digit adder: sums N_OPS signed samples per frame.
// Optional build macro RDA_ACC_SATURATE_EN clamps the accumulator on overflow instead of wrapping.
module rda_accumulator #(
    parameter int WIDTH = 32,
    parameter int N_OPS = 4
) (
    input logic              clk,
    input logic              rst,
    rda_accumulator_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

    localparam logic [7:0] LAST_CNT = 8'(N_OPS - 1);

    state_t           state;
    logic [WIDTH-1:0] acc;
    logic [7:0]       cnt;
    logic [7:0]       tag;
    logic             ovf;
    logic             out_valid;
    logic [WIDTH-1:0] out_data;
    logic [7:0]       out_tag;
    logic             out_ovf;

    logic [WIDTH:0]   sum_ext;
    logic             add_ovf;
    logic [WIDTH-1:0] acc_next;
    logic             take;

    assign bus.in_ready  = !rst && (state != DONE) && !bus.flush;
    assign take          = bus.in_valid && bus.in_ready;
    assign bus.out_valid = out_valid;
    assign bus.out_data  = out_data;
    assign bus.out_tag   = out_tag;
    assign bus.out_ovf   = out_ovf;

    // Sign-extended sum: the top two bits disagree exactly when the WIDTH-bit result overflowed.
    // NOTE: every always_comb output gets a default on entry so no path can infer a latch.
    always_comb begin
        sum_ext  = {acc[WIDTH-1], acc} + {bus.in_data[WIDTH-1], bus.in_data};
        add_ovf  = sum_ext[WIDTH] ^ sum_ext[WIDTH-1];
        acc_next = sum_ext[WIDTH-1:0];
`ifdef RDA_ACC_SATURATE_EN
        if (add_ovf) begin
            acc_next = sum_ext[WIDTH] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
        end
`endif
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            acc       <= '0;
            cnt       <= '0;
            tag       <= '0;
            ovf       <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_tag   <= '0;
            out_ovf   <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (take) begin
                        acc <= bus.in_data;
                        tag <= bus.in_tag;
                        ovf <= 1'b0;
                        cnt <= 8'd1;
                        if (N_OPS == 1) begin
                            state     <= DONE;
                            out_valid <= 1'b1;
                            out_data  <= bus.in_data;
                            out_tag   <= bus.in_tag;
                            out_ovf   <= 1'b0;
                        end else begin
                            state <= ACCUM;
                        end
                    end
                end
                ACCUM: begin
                    if (bus.flush) begin
                        state <= IDLE;
                        acc   <= '0;
                        cnt   <= '0;
                    end else if (take) begin
                        acc <= acc_next;
                        cnt <= cnt + 8'd1;
                        ovf <= ovf | add_ovf;
                        if (cnt == LAST_CNT) begin
                            state     <= DONE;
                            out_valid <= 1'b1;
                            out_data  <= acc_next;
                            out_tag   <= tag;
                            out_ovf   <= ovf | add_ovf;
                        end
                    end
                end
                DONE: begin
                    // Result stays frozen until downstream takes it; no bypass into the next frame.
                    if (bus.out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        cnt       <= '0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_rda_accumulator.sv
// Directed self-checking bench for rda_accumulator (N_OPS=4 and N_OPS=1 instances).
// Expected values follow the RDA_ACC_SATURATE_EN build when that macro is defined.
module tb_rda_accumulator;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   passed = 0;
    int   total  = 0;

    always #5 clk = ~clk;

    rda_accumulator_if #(.WIDTH(32)) bus0 ();
    rda_accumulator_if #(.WIDTH(32)) bus1 ();

    rda_accumulator #(.WIDTH(32), .N_OPS(4)) dut0 (.clk(clk), .rst(rst), .bus(bus0.slave));
    rda_accumulator #(.WIDTH(32), .N_OPS(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1.slave));

`ifdef RDA_ACC_SATURATE_EN
    localparam logic [31:0] POS_OVF_RES = 32'h7FFF_FFFF;
    localparam logic [31:0] NEG_OVF_RES = 32'h8000_0000;
`else
    localparam logic [31:0] POS_OVF_RES = 32'h8000_0000;
    localparam logic [31:0] NEG_OVF_RES = 32'h7FFF_FFFF;
`endif

    task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) begin
            passed++;
        end else begin
            $error("FAIL %s: observed %h expected %h", name, obs, exp);
        end
    endtask

    // Present one sample on the N_OPS=4 instance and let it transfer on the next rising edge.
    task automatic send0(input logic [31:0] d, input logic [7:0] t);
        @(negedge clk);
        bus0.in_valid = 1'b1;
        bus0.in_data  = d;
        bus0.in_tag   = t;
        #1;
        check("in_ready_at_send", 32'(bus0.in_ready), 32'd1);
        @(posedge clk);
        #1;
    endtask

    // Result checks in DONE, then the handshake (out_ready=1) and return to IDLE.
    task automatic frame_end0(input string name, input logic [31:0] d, input logic [7:0] t,
                              input logic o);
        @(negedge clk);
        bus0.in_valid = 1'b0;
        check({name, "_out_valid"}, 32'(bus0.out_valid), 32'd1);
        check({name, "_out_data"}, bus0.out_data, d);
        check({name, "_out_tag"}, 32'(bus0.out_tag), 32'(t));
        check({name, "_out_ovf"}, 32'(bus0.out_ovf), 32'(o));
        check({name, "_in_ready_done"}, 32'(bus0.in_ready), 32'd0);
        @(negedge clk);
        check({name, "_out_valid_drop"}, 32'(bus0.out_valid), 32'd0);
        check({name, "_in_ready_back"}, 32'(bus0.in_ready), 32'd1);
    endtask

    task automatic frame1(input logic [31:0] d);
        @(negedge clk);
        bus1.in_valid = 1'b1;
        bus1.in_data  = d;
        bus1.in_tag   = "s";
        @(negedge clk);
        bus1.in_valid = 1'b0;
        check("n1_out_valid", 32'(bus1.out_valid), 32'd1);
        check("n1_out_data", bus1.out_data, d);
        check("n1_out_tag", 32'(bus1.out_tag), 32'(8'h73));
        check("n1_out_ovf", 32'(bus1.out_ovf), 32'd0);
        @(negedge clk);
        check("n1_out_valid_drop", 32'(bus1.out_valid), 32'd0);
    endtask

    initial begin
        bus0.in_valid = 1'b0; bus0.in_data = '0; bus0.in_tag = '0; bus0.flush = 1'b0;
        bus0.out_ready = 1'b1;
        bus1.in_valid = 1'b0; bus1.in_data = '0; bus1.in_tag = '0; bus1.flush = 1'b0;
        bus1.out_ready = 1'b1;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_out_valid", 32'(bus0.out_valid), 32'd0);
        check("rst_out_data", bus0.out_data, 32'd0);
        check("rst_out_tag", 32'(bus0.out_tag), 32'd0);
        check("rst_out_ovf", 32'(bus0.out_ovf), 32'd0);
        check("rst_in_ready", 32'(bus0.in_ready), 32'd0);
        check("rst_n1_out_valid", 32'(bus1.out_valid), 32'd0);
        rst = 1'b0;
        #1;
        check("post_rst_in_ready", 32'(bus0.in_ready), 32'd1);

        // Basic frame: 36865 + 33023 - 36864 + 1 = 33025
        send0(32'd36865, "k");
        send0(32'd33023, "a");
        send0(32'(-36864), "b");
        check("basic_no_early_valid", 32'(bus0.out_valid), 32'd0);
        send0(32'd1, "c");
        frame_end0("basic", 32'd33025, "k", 1'b0);

        // N_OPS=1: each sample is its own frame
        frame1(32'd1);
        frame1(32'hFFFF_FFFF);
        frame1(32'd69888);

        // Positive and negative overflow
        send0(32'h7FFF_FFFF, "o");
        send0(32'd1, "p");
        send0(32'd0, "q");
        send0(32'd0, "r");
        frame_end0("ovf_pos", POS_OVF_RES, "o", 1'b1);
        send0(32'h8000_0000, "n");
        send0(32'hFFFF_FFFF, "p");
        send0(32'd0, "q");
        send0(32'd0, "r");
        frame_end0("ovf_neg", NEG_OVF_RES, "n", 1'b1);

        // Backpressure: result held for 3 cycles while upstream keeps offering data
        bus0.out_ready = 1'b0;
        send0(32'd1, "b");
        send0(32'd2, "c");
        send0(32'd3, "d");
        send0(32'd4, "e");
        @(negedge clk);
        bus0.in_data = 32'd99;
        bus0.in_tag  = "z";
        for (int i = 0; i < 3; i++) begin
            check("bp_out_valid", 32'(bus0.out_valid), 32'd1);
            check("bp_out_data", bus0.out_data, 32'd10);
            check("bp_out_tag", 32'(bus0.out_tag), 32'(8'h62));
            check("bp_out_ovf_cleared", 32'(bus0.out_ovf), 32'd0);
            check("bp_in_ready", 32'(bus0.in_ready), 32'd0);
            @(negedge clk);
        end
        bus0.in_valid  = 1'b0;
        bus0.out_ready = 1'b1;
        @(negedge clk);
        check("bp_out_valid_drop", 32'(bus0.out_valid), 32'd0);
        check("bp_in_ready_back", 32'(bus0.in_ready), 32'd1);

        // Flush mid-frame with a sample offered in the same cycle
        send0(32'd5, "f");
        send0(32'd7, "g");
        @(negedge clk);
        bus0.in_valid = 1'b1;
        bus0.in_data  = 32'd100;
        bus0.flush    = 1'b1;
        #1;
        check("flush_in_ready", 32'(bus0.in_ready), 32'd0);
        @(negedge clk);
        bus0.flush    = 1'b0;
        bus0.in_valid = 1'b0;
        check("flush_no_valid", 32'(bus0.out_valid), 32'd0);
        send0(32'd1, "1");
        send0(32'd2, "2");
        send0(32'd3, "3");
        send0(32'd4, "4");
        frame_end0("flush", 32'd10, "1", 1'b0);

        // Reset mid-frame discards the partial sum and clears held outputs
        send0(32'd10, "x");
        send0(32'd20, "x");
        send0(32'd30, "x");
        @(negedge clk);
        bus0.in_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        check("mid_rst_out_valid", 32'(bus0.out_valid), 32'd0);
        check("mid_rst_out_data", bus0.out_data, 32'd0);
        check("mid_rst_out_tag", 32'(bus0.out_tag), 32'd0);
        check("mid_rst_out_ovf", 32'(bus0.out_ovf), 32'd0);
        check("mid_rst_in_ready", 32'(bus0.in_ready), 32'd0);
        rst = 1'b0;
        #1;
        check("after_rst_out_data", bus0.out_data, 32'd0);
        send0(32'd10, "t");
        send0(32'd10, "u");
        send0(32'd10, "v");
        send0(32'd10, "w");
        frame_end0("after_rst", 32'd40, "t", 1'b0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
